// File: rtl/beta_inst_queue_pkg.sv
// rtl/beta_inst_queue_pkg.sv - Beta instruction types, opcode constants and literal helper.
package beta_inst_queue_pkg;

  typedef logic [31:0] inst_t;

  typedef enum logic [2:0] {
    CLS_REG     = 3'd0,
    CLS_LIT     = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_ILLEGAL = 3'd7
  } inst_class_e;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;
  localparam logic [5:0] REG_LO = 6'h20;
  localparam logic [5:0] REG_HI = 6'h2E;
  localparam logic [5:0] LIT_LO = 6'h30;
  localparam logic [5:0] LIT_HI = 6'h3E;

  typedef struct packed {
    inst_t       inst;
    inst_class_e cls;
  } entry_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/beta_inst_queue_if.sv
// rtl/beta_inst_queue_if.sv - Generator-side push and driver-side pop signals of the queue.
// ill_cnt is present only when BETA_ILLEGAL_FILTER_EN is defined.
interface beta_inst_queue_if
  import beta_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);

  logic                     in_valid;
  inst_t                    in_inst;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  inst_t                    out_inst;
  inst_class_e              out_class;
  logic [5:0]               out_op;
  logic [4:0]               out_dest;
  logic [4:0]               out_src1;
  logic [4:0]               out_src2;
  logic [31:0]              out_lit;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         drop_cnt;
`ifdef BETA_ILLEGAL_FILTER_EN
  logic [CNT_W-1:0]         ill_cnt;
`endif

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_inst, out_class, out_op, out_dest,
           out_src1, out_src2, out_lit, level, drop_cnt
`ifdef BETA_ILLEGAL_FILTER_EN
    , output ill_cnt
`endif
  );

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_inst, out_class, out_op, out_dest,
           out_src1, out_src2, out_lit, level, drop_cnt
`ifdef BETA_ILLEGAL_FILTER_EN
    , input ill_cnt
`endif
  );

endinterface

// File: rtl/beta_inst_classify.sv
// rtl/beta_inst_classify.sv - Combinational Beta opcode to instruction class decoder.
module beta_inst_classify
  import beta_inst_queue_pkg::*;
(
  input  logic [5:0]  op,
  output inst_class_e cls
);

  // Slot 7 of each arithmetic octet (0x27, 0x2F, 0x37, 0x3F) is unassigned.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (op >= REG_LO && op <= REG_HI && op[2:0] != 3'b111) begin
      cls = CLS_REG;
    end else if (op >= LIT_LO && op <= LIT_HI && op[2:0] != 3'b111) begin
      cls = CLS_LIT;
    end else if (op == OP_JMP || op == OP_BEQ || op == OP_BNE) begin
      cls = CLS_BRANCH;
    end else if (op == OP_LD || op == OP_LDR) begin
      cls = CLS_LOAD;
    end else if (op == OP_ST) begin
      cls = CLS_STORE;
    end
  end

endmodule

// File: rtl/beta_inst_queue.sv
// rtl/beta_inst_queue.sv - Show-ahead FIFO of classified Beta instructions with drop counting.
// Define BETA_ILLEGAL_FILTER_EN to discard ILLEGAL instructions at entry and count them in ill_cnt.
module beta_inst_queue
  import beta_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
)(
  input  logic           CLK,
  input  logic           RESET_N,
  beta_inst_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_int_n;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  inst_class_e      in_cls;
  entry_t           head;
  logic             in_ready, out_valid, filt, push, pop, drop;

  // Reset asserts immediately but releases two edges later, clear of CLK.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  beta_inst_classify u_classify (
    .op  (bus.in_inst[31:26]),
    .cls (in_cls)
  );

  always_comb begin
    in_ready  = (level_q < LW'(DEPTH)) || bus.out_ready;
    out_valid = (level_q != '0);
`ifdef BETA_ILLEGAL_FILTER_EN
    filt      = bus.in_valid && (in_cls == CLS_ILLEGAL);
`else
    filt      = 1'b0;
`endif
    push      = bus.in_valid && in_ready && !filt;
    drop      = bus.in_valid && !in_ready && !filt;
    pop       = out_valid && bus.out_ready;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{inst: bus.in_inst, cls: in_cls};
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
    drop_d   = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

`ifdef BETA_ILLEGAL_FILTER_EN
  logic [CNT_W-1:0] ill_q, ill_d;

  assign ill_d       = (filt && ill_q != '1) ? ill_q + 1'b1 : ill_q;
  assign bus.ill_cnt = ill_q;

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) ill_q <= '0;
    else            ill_q <= ill_d;
  end
`endif

  // Head fields are forced to zero whenever nothing is valid.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_inst  = '0;
    bus.out_class = CLS_REG;
    bus.out_op    = '0;
    bus.out_dest  = '0;
    bus.out_src1  = '0;
    bus.out_src2  = '0;
    bus.out_lit   = '0;
    if (out_valid) begin
      bus.out_inst  = head.inst;
      bus.out_class = head.cls;
      bus.out_op    = head.inst[31:26];
      bus.out_dest  = head.inst[25:21];
      bus.out_src1  = head.inst[20:16];
      bus.out_src2  = (head.cls == CLS_REG) ? head.inst[15:11] : 5'd0;
      bus.out_lit   = (head.cls == CLS_REG) ? 32'd0 : sext16(head.inst[15:0]);
    end
    bus.level    = level_q;
    bus.drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_beta_inst_queue.sv
// tb/tb_beta_inst_queue.sv - Directed and randomized checks of beta_inst_queue against a queue model.
module tb_beta_inst_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beta_inst_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  beta_inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q[$];
  int          drops = 0;
  int          ills  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int model_class(input int op);
    if (op inside {[32:38], [40:46]}) return 0;
    if (op inside {[48:54], [56:62]}) return 1;
    if (op inside {27, 28, 29})       return 2;
    if (op inside {24, 31})           return 3;
    if (op == 25)                     return 4;
    return 7;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] x;
    x = $urandom;
    while (model_class(int'(x[31:26])) == 7) x = $urandom;
    return x;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic rdy);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    #1;
  endtask

  // Advances one clock and applies the queue rules to the model.
  task automatic advance();
    bit          rdy_e, filt, v, r;
    logic [31:0] x;
    v = bus.in_valid;
    r = bus.out_ready;
    x = bus.in_inst;
    rdy_e = (q.size() < DEPTH) || r;
    filt = 1'b0;
`ifdef BETA_ILLEGAL_FILTER_EN
    filt = v && (model_class(int'(x[31:26])) == 7);
`endif
    @(posedge clk);
    if (r && q.size() > 0) void'(q.pop_front());
    if (v && !filt) begin
      if (rdy_e) q.push_back(x);
      else if (drops < 65535) drops++;
    end
    if (filt && ills < 65535) ills++;
    @(negedge clk);
  endtask

  task automatic check_head();
    logic [31:0] x;
    int          c;
    if (q.size() == 0) begin
      check("out_valid_empty", 32'(bus.out_valid), 32'd0);
      check("out_inst_empty", bus.out_inst, 32'd0);
      check("out_lit_empty", bus.out_lit, 32'd0);
    end else begin
      x = q[0];
      c = model_class(int'(x[31:26]));
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("out_inst", bus.out_inst, x);
      check("out_class", 32'(bus.out_class), 32'(c));
      check("out_op", 32'(bus.out_op), 32'(x[31:26]));
      check("out_dest", 32'(bus.out_dest), 32'(x[25:21]));
      check("out_src1", 32'(bus.out_src1), 32'(x[20:16]));
      check("out_src2", 32'(bus.out_src2), (c == 0) ? 32'(x[15:11]) : 32'd0);
      check("out_lit", bus.out_lit, (c == 0) ? 32'd0 : {{16{x[15]}}, x[15:0]});
    end
  endtask

  initial begin
    drive(1'b0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_drop", 32'(bus.drop_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_inst", bus.out_inst, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // ADD R1,R2,R3
    drive(1'b1, 32'h8022_1800, 1'b0); advance();
    drive(1'b0, 32'd0, 1'b0);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_class", 32'(bus.out_class), 32'd0);
    check("add_dest", 32'(bus.out_dest), 32'd1);
    check("add_src1", 32'(bus.out_src1), 32'd2);
    check("add_src2", 32'(bus.out_src2), 32'd3);
    check("add_lit", bus.out_lit, 32'd0);
    drive(1'b0, 32'd0, 1'b1); advance();

    // ADDC R5,R3,-1
    drive(1'b1, 32'hC0A3_FFFF, 1'b0); advance();
    drive(1'b0, 32'd0, 1'b0);
    check("addc_class", 32'(bus.out_class), 32'd1);
    check("addc_lit", bus.out_lit, 32'hFFFF_FFFF);
    check("addc_src2", 32'(bus.out_src2), 32'd0);
    check("addc_dest", 32'(bus.out_dest), 32'd5);
    drive(1'b0, 32'd0, 1'b1); advance();
    check("empty_after_pop", 32'(bus.out_valid), 32'd0);

    // Overfill by two
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_legal(), 1'b0); advance();
    end
    drive(1'b0, 32'd0, 1'b0);
    check("full_level", 32'(bus.level), 32'd8);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_drop", 32'(bus.drop_cnt), 32'd2);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rand_legal(), 1'b1);
      check("stream_level", 32'(bus.level), 32'd8);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      check("stream_inst", bus.out_inst, q[0]);
      advance();
    end
    drive(1'b0, 32'd0, 1'b0);
    check("stream_drop", 32'(bus.drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'd0, 1'b1);
      check_head();
      advance();
    end
    check("drained_level", 32'(bus.level), 32'd0);

    // Unassigned opcode 0x27
    drive(1'b1, 32'h9C00_0000, 1'b0); advance();
    drive(1'b0, 32'd0, 1'b0);
`ifdef BETA_ILLEGAL_FILTER_EN
    check("ill_filtered_valid", 32'(bus.out_valid), 32'd0);
    check("ill_cnt", 32'(bus.ill_cnt), 32'd1);
`else
    check("ill_valid", 32'(bus.out_valid), 32'd1);
    check("ill_class", 32'(bus.out_class), 32'd7);
`endif
    check("ill_drop", 32'(bus.drop_cnt), 32'(drops));
    drive(1'b0, 32'd0, 1'b1); advance();

    // Randomized traffic, push-heavy then pop-heavy
    for (int i = 0; i < 400; i++) begin
      if (i < 200) drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0);
      else         drive($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0);
      check("rnd_in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) || bus.out_ready));
      check("rnd_level", 32'(bus.level), 32'(q.size()));
      check("rnd_drop", 32'(bus.drop_cnt), 32'(drops));
`ifdef BETA_ILLEGAL_FILTER_EN
      check("rnd_ill", 32'(bus.ill_cnt), 32'(ills));
`endif
      check_head();
      advance();
    end

    // Asynchronous reset with five entries queued
    drive(1'b0, 32'd0, 1'b1);
    while (q.size() > 0) advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rand_legal(), 1'b0); advance();
    end
    drive(1'b0, 32'd0, 1'b0);
    check("pre_rst_level", 32'(bus.level), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_level", 32'(bus.level), 32'd0);
    check("async_drop", 32'(bus.drop_cnt), 32'd0);
    check("async_out_inst", bus.out_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_level", 32'(bus.level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/beta_inst_queue.md
Name: beta_inst_queue

Overview:
- Sits directly downstream of the random Beta instruction generator.
- Captures one 32-bit Beta instruction per CLK when offered and buffers it in a FIFO.
- Decodes each instruction into class, register fields and a sign-extended literal.
- Presents decoded instructions to the DUT driver through a valid/ready handshake, and counts instructions lost to overflow. The generator has no backpressure.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the drop counter (saturating).

Ports:
- CLK  input  1  clock, all state updates on posedge.
- RESET_N  input  1  asynchronous active-low reset.
- in_valid  input  1  generator instruction valid this cycle.
- in_inst  input  32  instruction (inst_t from my_pkg).
- in_ready  output  1  push will be accepted this cycle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- out_inst  output  32  raw head instruction.
- out_class  output  3  inst_class_e of head.
- out_op  output  6  opcode [31:26].
- out_dest  output  5  Rc [25:21].
- out_src1  output  5  Ra [20:16].
- out_src2  output  5  Rb [15:11]; 0 for non-REG classes.
- out_lit  output  32  literal [15:0] sign-extended; 0 for REG class.
- level  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  CNT_W  offered-but-rejected instructions.

Behaviour:
- Reset (async assert, sync deassert internally):
  - pointers = 0, level = 0, drop_cnt = 0, out_valid = 0.
  - All out_* data = 0; in_ready = 1.
- Classification on entry, stored with the entry:
  - REG: 0x20-0x26, 0x28-0x2E.
  - LIT: 0x30-0x36, 0x38-0x3E.
  - BRANCH: 0x1B-0x1D.
  - LOAD: 0x18, 0x1F.
  - STORE: 0x19.
  - ILLEGAL: all other opcodes.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (level < DEPTH) || out_ready. Full FIFO with simultaneous pop accepts the push.
- Show-ahead output, registered storage:
  - An instruction pushed at edge N is visible on out_* after edge N.
  - No same-cycle bypass when empty.
- out_* hold stable while out_valid && !out_ready.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- in_valid && !in_ready:
  - Instruction is discarded.
  - drop_cnt increments, saturating at all-ones.
- Pop on empty is ignored; out_valid = 0 masks out_ready.
- Reset mid-operation flushes all entries immediately. drop_cnt clears.
- No X propagation: out_* driven 0 when out_valid = 0.

Optional Feature:
- Macro BETA_ILLEGAL_FILTER_EN.
- Defined:
  - ILLEGAL-class instructions are never written into the FIFO.
  - They do not count as drops.
  - Extra output ill_cnt (CNT_W, saturating, reset 0) increments per filtered instruction.
- Not defined:
  - ILLEGAL instructions are queued like any other, with out_class = ILLEGAL.
  - ill_cnt port is absent.

Decomposition:
- my_pkg additions:
  - inst_class_e enum: REG=0, LIT=1, BRANCH=2, LOAD=3, STORE=4, ILLEGAL=7.
  - Opcode range constants: OP_LD, OP_ST, OP_LDR, OP_JMP, OP_BEQ, OP_BNE, REG_LO/HI, LIT_LO/HI.
  - Helper function sext16.
- Sub-module beta_inst_classify: purely combinational opcode-to-inst_class_e decoder, reused by the scoreboard.

Test Plan:
- Reset, then push 0x80221800 (ADD R1,R2,R3) -> next cycle:
  - out_valid = 1, out_class = REG.
  - out_dest = 1, out_src1 = 2, out_src2 = 3, out_lit = 0.
- Push 0xC0A3FFFF (ADDC R5,R3,-1) -> out_class = LIT, out_lit = 0xFFFFFFFF, out_src2 = 0.
- out_ready = 0, push 8 instrs, then a 9th, then a 10th:
  - level = 8, in_ready = 0, drop_cnt = 2.
  - Draining returns the first 8 in order.
- Full FIFO, in_valid = 1 and out_ready = 1 for 20 cycles -> level stays 8, drop_cnt unchanged, order preserved across pointer wrap.
- Push 0x9C000000 (op 0x27) -> without macro: out_class = ILLEGAL; with BETA_ILLEGAL_FILTER_EN: out_valid stays 0 and ill_cnt = 1.
- Assert RESET_N = 0 mid-stream with level = 5 -> out_valid = 0, level = 0, drop_cnt = 0 asynchronously, before the next CLK edge.
